// File: rtl/snoop_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : snoop_bus_ctrl
// Description : Two-cache snoopy coherence bus controller with write-back,
//               cache-to-cache transfer, memory read and invalidate paths.
//               Define SNOOP_RR_ARB_EN for round-robin arbitration
//               (fixed priority to cache 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_bus_ctrl (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       cache_dREN,
    input  logic [1:0]       cache_dWEN,
    input  logic [1:0][31:0] dcache_addr,
    input  logic [1:0][31:0] dcache_data,
    input  logic [1:0]       cctrans,
    input  logic [1:0]       ccwrite,
    output logic [1:0]       cache_dwait,
    output logic [1:0][31:0] cache_dload,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output logic [1:0][31:0] snoopy_addr,
    output logic             dREN,
    output logic             dWEN,
    output logic [31:0]      daddr,
    output logic [31:0]      dstore,
    input  logic [31:0]      dload,
    input  logic             dwait
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_wb    = 3'd1;
    localparam logic [2:0] c_snoop = 3'd2;
    localparam logic [2:0] c_c2c   = 3'd3;
    localparam logic [2:0] c_memrd = 3'd4;
    localparam logic [2:0] c_inv   = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_req;
    logic       w_oth;
    logic       w_grant;
    logic       w_done;
    logic [1:0] w_want;

    // A cache wants the bus for a write-back, a read miss, or an upgrade.
    assign w_want = cache_dREN | cache_dWEN | (cctrans & ccwrite);
    assign w_oth  = ~r_req;

`ifdef SNOOP_RR_ARB_EN
    logic r_ptr;

    assign w_grant = (&w_want) ? r_ptr : (w_want[1] & ~w_want[0]);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ptr <= 1'b0;
        end else if (w_done) begin
            r_ptr <= ~r_req;
        end
    end
`else
    assign w_grant = w_want[1] & ~w_want[0];
`endif

    assign w_done = ((r_state == c_wb) || (r_state == c_c2c) || (r_state == c_memrd))
                    ? ~dwait : (r_state == c_inv);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (|w_want) begin
                    if (cache_dWEN[w_grant])      w_next = c_wb;
                    else if (cache_dREN[w_grant]) w_next = c_snoop;
                    else                          w_next = c_inv;
                end
            end
            // The snooped cache holding a modified copy supplies the data.
            c_snoop: w_next = (cctrans[w_oth] & ccwrite[w_oth]) ? c_c2c : c_memrd;
            c_wb, c_c2c, c_memrd, c_inv: begin
                if (w_done) w_next = c_idle;
            end
            default: w_next = c_idle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= c_idle;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_idle) && (|w_want)) begin
                r_req <= w_grant;
            end
        end
    end

    always_comb begin
        cache_dwait = 2'b11;
        cache_dload = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        snoopy_addr = '0;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        daddr       = '0;
        dstore      = '0;
        case (r_state)
            c_wb: begin
                dWEN               = 1'b1;
                daddr              = dcache_addr[r_req];
                dstore             = dcache_data[r_req];
                cache_dwait[r_req] = dwait;
            end
            c_snoop: begin
                ccwait[w_oth]      = 1'b1;
                ccinv[w_oth]       = ccwrite[r_req];
                snoopy_addr[w_oth] = dcache_addr[r_req];
            end
            c_c2c: begin
                // Memory is updated with the dirty line while it is forwarded.
                ccwait[w_oth]      = 1'b1;
                dWEN               = 1'b1;
                daddr              = dcache_addr[r_req];
                dstore             = dcache_data[w_oth];
                cache_dload[r_req] = dcache_data[w_oth];
                if (!dwait) cache_dwait = 2'b00;
            end
            c_memrd: begin
                dREN               = 1'b1;
                daddr              = dcache_addr[r_req];
                cache_dload[r_req] = dload;
                cache_dwait[r_req] = dwait;
            end
            c_inv: begin
                ccwait[w_oth]      = 1'b1;
                ccinv[w_oth]       = 1'b1;
                snoopy_addr[w_oth] = dcache_addr[r_req];
                cache_dwait[r_req] = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_snoop_bus_ctrl
// Description : Scoreboard bench for snoop_bus_ctrl with a transaction-level
//               reference model; honours SNOOP_RR_ARB_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_ctrl;

    localparam int c_wb   = 0;
    localparam int c_read = 1;
    localparam int c_inv  = 2;

    logic             CLK = 1'b0;
    logic             nRST = 1'b1;
    logic [1:0]       cache_dREN = '0, cache_dWEN = '0, cctrans = '0, ccwrite = '0;
    logic [1:0][31:0] dcache_addr = '0, dcache_data = '0;
    logic [1:0]       cache_dwait, ccwait, ccinv;
    logic [1:0][31:0] cache_dload, snoopy_addr;
    logic             dREN, dWEN;
    logic [31:0]      daddr, dstore;
    logic [31:0]      dload = '0;
    logic             dwait = 1'b1;

    snoop_bus_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .cache_dREN(cache_dREN), .cache_dWEN(cache_dWEN),
        .dcache_addr(dcache_addr), .dcache_data(dcache_data),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .cache_dwait(cache_dwait), .cache_dload(cache_dload),
        .ccwait(ccwait), .ccinv(ccinv), .snoopy_addr(snoopy_addr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [1:0]       cdw;
        logic [1:0][31:0] dl;
        logic             dren;
        logic             dwen;
        logic [31:0]      addr;
        logic [31:0]      store;
    } done_t;

    typedef struct {
        int               cyc;
        logic [1:0]       wait_v;
        logic [1:0]       inv_v;
        logic [1:0][31:0] saddr;
    } snp_t;

    done_t done_q[$];
    snp_t  snp_q[$];
    done_t md;
    snp_t  ms;
    int    errors = 0;
    int    checks = 0;
    bit    m_ptr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a completion or snoop.
    always @(negedge CLK) begin
        if (nRST) begin
            chk("dren_dwen_exclusive", 64'(dREN & dWEN), 64'd0);
            if (cache_dwait != 2'b11) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_completion", 64'(cache_dwait), 64'h3);
                end else begin
                    md = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(md.cyc));
                    chk("cache_dwait", 64'(cache_dwait), 64'(md.cdw));
                    chk("cache_dload", 64'(cache_dload), 64'(md.dl));
                    chk("mem_ren_wen", 64'({dREN, dWEN}), 64'({md.dren, md.dwen}));
                    chk("daddr", 64'(daddr), 64'(md.addr));
                    chk("dstore", 64'(dstore), 64'(md.store));
                end
            end
            if (ccwait != 2'b00) begin
                if (snp_q.size() == 0) begin
                    chk("unexpected_ccwait", 64'(ccwait), 64'd0);
                end else begin
                    ms = snp_q.pop_front();
                    chk("snoop_cycle", 64'(cyc), 64'(ms.cyc));
                    chk("ccwait", 64'(ccwait), 64'(ms.wait_v));
                    chk("ccinv", 64'(ccinv), 64'(ms.inv_v));
                    chk("snoopy_addr", 64'(snoopy_addr), 64'(ms.saddr));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference arbitration: ties alternate (round-robin) or go to cache 0.
    function automatic bit arb(input logic [1:0] who);
        if (who == 2'b11) begin
`ifdef SNOOP_RR_ARB_EN
            return m_ptr;
`else
            return 1'b0;
`endif
        end
        return who[1];
    endfunction

    task automatic push_done(input logic [1:0] cdw, input logic [1:0][31:0] dl, input logic dren,
                             input logic dwen, input logic [31:0] addr, input logic [31:0] store);
        done_t d;
        d.cyc = cyc; d.cdw = cdw; d.dl = dl; d.dren = dren; d.dwen = dwen;
        d.addr = addr; d.store = store;
        done_q.push_back(d);
    endtask

    task automatic push_snp(input logic [1:0] w, input logic [1:0] inv, input logic [1:0][31:0] sa);
        snp_t s;
        s.cyc = cyc; s.wait_v = w; s.inv_v = inv; s.saddr = sa;
        snp_q.push_back(s);
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after completion.
    task automatic run_txn(input logic [1:0] who, input int kind,
                           input logic [1:0][31:0] addr, input logic [1:0][31:0] data,
                           input logic [1:0] excl, input bit hit, input bit modi,
                           input int dly, input logic [31:0] mdata);
        bit g, o, c2c;
        logic [1:0] gm, om;
        logic [1:0][31:0] sa, dl;
        g = arb(who); o = ~g;
        gm = 2'b01 << g; om = 2'b01 << o;
        dcache_addr = addr; dcache_data = data; dwait = 1'b1;
        case (kind)
            c_wb:   cache_dWEN = who;
            c_read: begin cache_dREN = who; ccwrite = excl & who; end
            default: begin cctrans = who; ccwrite = who; end
        endcase
        tick();
        if (kind == c_wb) begin
            for (int k = 0; k <= dly; k++) begin
                dwait = (k != dly);
                if (k == dly) push_done(~gm, '0, 1'b0, 1'b1, addr[g], data[g]);
                tick();
            end
        end else if (kind == c_inv) begin
            sa = '0; sa[o] = addr[g];
            push_snp(om, om, sa);
            push_done(~gm, '0, 1'b0, 1'b0, 32'd0, 32'd0);
            tick();
        end else begin
            cctrans[o] = hit; ccwrite[o] = modi;
            c2c = hit & modi;
            sa = '0; sa[o] = addr[g];
            push_snp(om, excl[g] ? om : 2'b00, sa);
            tick();
            cctrans[o] = 1'b0; ccwrite[o] = 1'b0;
            for (int k = 0; k <= dly; k++) begin
                dwait = (k != dly);
                dload = (k == dly) ? mdata : $urandom;
                if (c2c) push_snp(om, 2'b00, '0);
                if (k == dly) begin
                    dl = '0;
                    if (c2c) begin
                        dl[g] = data[o];
                        push_done(2'b00, dl, 1'b0, 1'b1, addr[g], data[o]);
                    end else begin
                        dl[g] = mdata;
                        push_done(~gm, dl, 1'b1, 1'b0, addr[g], 32'd0);
                    end
                end
                tick();
            end
        end
        cache_dREN = '0; cache_dWEN = '0; cctrans = '0; ccwrite = '0;
        dwait = 1'b1; dload = '0;
        m_ptr = ~g;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cache_dwait"}, 64'(cache_dwait), 64'h3);
        chk({tag, "_ccwait_ccinv"}, 64'({ccwait, ccinv}), 64'd0);
        chk({tag, "_dren_dwen"}, 64'({dREN, dWEN}), 64'd0);
        chk({tag, "_daddr_dstore"}, {daddr, dstore}, 64'd0);
        chk({tag, "_snoopy_addr"}, 64'(snoopy_addr), 64'd0);
        chk({tag, "_cache_dload"}, 64'(cache_dload), 64'd0);
    endtask

    initial begin
        logic [1:0][31:0] a, d;
        logic [1:0]       who;
        int               kind;

        #1 nRST = 1'b0;
        #10;
        chk_idle_outputs("reset");
        tick();
        nRST = 1'b1;

        // Simultaneous reads: grants alternate with round-robin, else cache 0.
        for (int i = 0; i < 4; i++) begin
            a[0] = $urandom; a[1] = $urandom; d[0] = $urandom; d[1] = $urandom;
            run_txn(2'b11, c_read, a, d, 2'(i), 1'b0, 1'b0, 0, $urandom);
        end

        // Read miss by cache 0, memory answers on the third MEMRD cycle.
        a = '0; a[0] = 32'h100; d = '0;
        run_txn(2'b01, c_read, a, d, 2'b00, 1'b0, 1'b0, 2, 32'hDEADBEEF);

        // Exclusive read by cache 1 served by cache 0's modified copy.
        a = '0; a[1] = 32'h200; d = '0; d[0] = 32'h12345678;
        run_txn(2'b10, c_read, a, d, 2'b10, 1'b1, 1'b1, 0, 32'h0);

        // Upgrade by cache 0 without a data request.
        a = '0; a[0] = 32'h40; d = '0;
        run_txn(2'b01, c_inv, a, d, 2'b00, 1'b0, 1'b0, 0, 32'h0);

        for (int i = 0; i < 150; i++) begin
            who  = 2'($urandom_range(1, 3));
            kind = (who == 2'b11) ? c_read : int'($urandom_range(0, 2));
            a[0] = $urandom; a[1] = $urandom; d[0] = $urandom; d[1] = $urandom;
            run_txn(who, kind, a, d, 2'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), $urandom);
        end

        // Reset in the middle of a stalled memory read abandons it.
        a = '0; a[0] = 32'h300;
        dcache_addr = a; cache_dREN = 2'b01; dwait = 1'b1;
        tick();
        a[1] = 32'h300; a[0] = 32'h0;
        push_snp(2'b10, 2'b00, a);
        tick();
        chk("memrd_dren_before_reset", 64'(dREN), 64'd1);
        #2 nRST = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        cache_dREN = '0; dcache_addr = '0;
        tick();
        nRST = 1'b1;
        m_ptr = 1'b0;
        a[0] = 32'h0; a[1] = 32'h500; d = '0; d[1] = 32'hCAFEF00D;
        run_txn(2'b10, c_wb, a, d, 2'b00, 1'b0, 1'b0, 1, 32'h0);

        tick();
        tick();
        chk("done_queue_drained", 64'(done_q.size()), 64'd0);
        chk("snoop_queue_drained", 64'(snp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
